unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between PCPU's IF stage (inst_addr/inst_mem)
//  and MEM stage (data_addr/data_mem/data_we/data_write). Each access is a fixed
//  multi-cycle transaction.
//  Generates the pipeline stall (feeds remain_pc) while either requester waits.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  WAIT_CYC  2   memory access cycles per transaction (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous reset, active-low
//  if_req     in   1       fetch request, held until if_ack
//  if_addr    in   ADDR_W  fetch address
//  if_ack     out  1       fetch done; if_rdata valid this cycle
//  if_rdata   out  DATA_W  fetched instruction
//  d_req      in   1       data request, held until d_ack
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       data done; d_rdata valid this cycle
//  d_rdata    out  DATA_W  load data
//  mem_en     out  1       memory access active
//  mem_we     out  1       memory write strobe
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid on the last access cycle
//  stall      out  1       (if_req&~if_ack)|(d_req&~d_ack), combinational
// BEHAVIOUR
//  Reset (rst=0 at edge):
//   - state IDLE, cnt 0, last_served=I.
//   - mem_en/mem_we/mem_addr/mem_wdata 0; acks 0; rdata hold registers 0.
//   - Any in-flight transaction is abandoned with no ack.
//  FSM states: IDLE, BUSY_I, BUSY_D.
//  Grant:
//   - Evaluated at an edge in IDLE, or at the completion edge of a BUSY state.
//   - Only one requester pending -> grant it.
//   - Both pending -> grant the one != last_served, so the first contest after reset goes to D.
//   - Completion edge with a request pending -> enter the next BUSY state directly, no IDLE gap.
//   - Completion edge with nothing pending -> IDLE.
//  On grant:
//   - Latch addr, and for D also we/wdata, into output registers.
//   - cnt <= WAIT_CYC-1; last_served <= winner.
//  BUSY_x:
//   - mem_en=1, mem_addr=latched addr.
//   - mem_we = latched we in BUSY_D only; always 0 in BUSY_I.
//   - cnt decrements each edge.
//   - Completion cycle is cnt==0: x_ack=1 (combinational from state/cnt) and x_rdata=mem_rdata.
//   - At the completion edge mem_rdata is captured into the x hold register.
//  Outside its ack cycle, x_rdata shows the hold register. Loads and IF only; a store leaves d_rdata hold unchanged.
//  Latency: req visible in IDLE cycle t -> mem_en cycles t+1..t+WAIT_CYC -> ack in cycle t+WAIT_CYC.
//  Handshake:
//   - The request is consumed at the grant edge.
//   - req high in the cycle after ack is a new request.
//   - Dropping req mid-BUSY does not cancel; ack still pulses and is ignored.
//   - addr/wdata changes after grant are ignored.
//  IDLE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last values.
//  Addresses pass through unmodified (no alignment or decoding).
// TESTING
//  1 WAIT_CYC=2, IF request:
//    - Stimulus: if_req=1, if_addr=0x4 in cycle 0; mem_rdata=0x20040003.
//    - Response: mem_en in cycles 1-2; if_ack in cycle 2 with if_rdata=0x20040003; stall=1 in cycles 0-1, 0 in cycle 2.
//  2 Store with competing fetch:
//    - Stimulus: d_req=1, d_we=1, d_addr=0xE0000000, d_wdata=7, plus if_req=1, all in cycle 0.
//    - Response: mem_we=1, mem_addr=0xE0000000, mem_wdata=7 in cycles 1-2; d_ack in cycle 2.
//    - Then BUSY_I in cycles 3-4 with mem_we=0; if_ack in cycle 4.
//  3 Both requests held continuously:
//    - Response: grants alternate D,I,D,I; one ack every WAIT_CYC cycles; no IDLE cycles.
//  4 Reset mid-transaction:
//    - Stimulus: rst=0 during cycle 1 of BUSY_D.
//    - Response: next cycle is IDLE, mem_en=0, mem_addr=0, no d_ack, d_rdata=0.
//  5 WAIT_CYC=1, if_req held with a changing address:
//    - Response: first if_ack 1 cycle after the request, then one if_ack every cycle, each carrying the address latched at its own grant.
//  6 Load, then an idle fetch port:
//    - Stimulus: load with mem_rdata=0x55 at completion, then mem_rdata changes.
//    - Response: d_rdata stays 0x55 after the ack.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported memory between the instruction-fetch port (I) and
// the data port (D). Every access occupies the memory for WAIT_CYC cycles.
// When both ports are waiting, the one not served last wins. A new transaction
// can start on the completion edge of the previous one, so there is no idle gap.
// The stall output is high while either port has a request that is not being
// acknowledged in the current cycle.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    // The counter needs at least one bit, even when WAIT_CYC is 1.
    localparam int              CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_d_q;   // 1: D was served last, 0: I was served last
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] if_hold_q;
    logic [DATA_W-1:0] d_hold_q;
    logic              done;
    logic              grant_i, grant_d;

    // The final access cycle of a transaction is the cycle in which the counter reaches zero.
    assign done = (state_q != IDLE) && (cnt_q == '0);

    // Grant selection and next state. A grant is only possible while idle or on a completion edge.
    always_comb begin
        // NOTE: every signal gets a default before any branch. A path that leaves a
        // combinational output unassigned would make synthesis infer a latch.
        grant_i = 1'b0;
        grant_d = 1'b0;
        state_d = state_q;
        if ((state_q == IDLE) || done) begin
            if (if_req && d_req) begin
                grant_d = ~last_d_q;
                grant_i = last_d_q;
            end else begin
                grant_i = if_req;
                grant_d = d_req;
            end
            if (grant_d)      state_d = BUSY_D;
            else if (grant_i) state_d = BUSY_I;
            else              state_d = IDLE;
        end
    end

    // State, access counter, fairness bit, and the address and write data latched at grant.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop therefore
        // samples its pre-edge value, whatever order the statements appear in.
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                addr_q   <= d_addr;
                we_q     <= d_we;
                wdata_q  <= d_wdata;
                cnt_q    <= CNT_LOAD;
                last_d_q <= 1'b1;
            end else if (grant_i) begin
                addr_q   <= if_addr;
                cnt_q    <= CNT_LOAD;
                last_d_q <= 1'b0;
            end else if ((state_q != IDLE) && !done) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // On the completion edge, capture read data into the hold register of the port being served.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else if (done) begin
            if (state_q == BUSY_I)             if_hold_q <= mem_rdata;
            if ((state_q == BUSY_D) && !we_q)  d_hold_q  <= mem_rdata;
        end
    end

    // Memory side. The address and write data keep their last values while idle.
    assign mem_en    = (state_q != IDLE);
    assign mem_we    = (state_q == BUSY_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Requester side. Read data bypasses the hold register during the ack cycle.
    assign if_ack   = done && (state_q == BUSY_I);
    assign d_ack    = done && (state_q == BUSY_D);
    assign if_rdata = if_ack ? mem_rdata : if_hold_q;
    assign d_rdata  = d_ack  ? mem_rdata : d_hold_q;
    assign stall    = (if_req && !if_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter. The main instance uses WAIT_CYC=2.
// A second instance uses WAIT_CYC=1 for back-to-back single-cycle fetches.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic        if_ack,  d_ack,  mem_en,  mem_we,  stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack1, d_ack1, mem_en1, mem_we1, stall1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

    int total = 0;
    int bad   = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with all inputs quiet, then release it. Returns in cycle 0.
    task automatic do_reset();
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (mem_en !== 1'b0)     begin bad++; $display("FAIL reset_mem_en got=%0h exp=0", mem_en); end
        total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
        total++; if (mem_addr !== 32'h0)  begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        total++; if ({if_ack, d_ack, stall} !== 3'b000)
            begin bad++; $display("FAIL reset_acks_stall got=%b exp=000", {if_ack, d_ack, stall}); end
        total++; if (if_rdata !== 32'h0)  begin bad++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
        total++; if (d_rdata !== 32'h0)   begin bad++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        total++; if ({d_rdata1, mem_wdata1} !== 64'h0)
            begin bad++; $display("FAIL reset_w1_regs got=%h exp=0", {d_rdata1, mem_wdata1}); end
    endtask

    task automatic test_if_fetch();
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h4;
        mem_rdata = 32'h2004_0003;
        @(negedge clk);
        total++; if ({mem_en, stall, if_ack} !== 3'b010)
            begin bad++; $display("FAIL if_c0 en/stall/ack got=%b exp=010", {mem_en, stall, if_ack}); end
        next_cycle();
        @(negedge clk);
        total++; if ({mem_en, mem_we, stall, if_ack} !== 4'b1010)
            begin bad++; $display("FAIL if_c1 en/we/stall/ack got=%b exp=1010", {mem_en, mem_we, stall, if_ack}); end
        total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL if_c1_addr got=%h exp=4", mem_addr); end
        next_cycle();
        @(negedge clk);
        total++; if ({mem_en, stall, if_ack} !== 3'b101)
            begin bad++; $display("FAIL if_c2 en/stall/ack got=%b exp=101", {mem_en, stall, if_ack}); end
        total++; if (if_rdata !== 32'h2004_0003)
            begin bad++; $display("FAIL if_c2_rdata got=%h exp=20040003", if_rdata); end
        // The request is still high on the completion edge, so a second fetch begins.
        // Away from an ack cycle, if_rdata must show the captured word.
        next_cycle();
        if_req    = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (if_rdata !== 32'h2004_0003)
            begin bad++; $display("FAIL if_hold got=%h exp=20040003", if_rdata); end
    endtask

    task automatic test_store_fetch();
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'hE000_0000;
        d_wdata   = 32'h7;
        if_req    = 1'b1;
        if_addr   = 32'h100;
        mem_rdata = 32'h11;
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            @(negedge clk);
            total++; if ({mem_en, mem_we} !== 2'b11)
                begin bad++; $display("FAIL st_c%0d en/we got=%b exp=11", c, {mem_en, mem_we}); end
            total++; if (mem_addr !== 32'hE000_0000 || mem_wdata !== 32'h7)
                begin bad++; $display("FAIL st_c%0d addr/wdata got=%h/%h exp=e0000000/7", c, mem_addr, mem_wdata); end
            total++; if ({d_ack, if_ack} !== ((c == 2) ? 2'b10 : 2'b00))
                begin bad++; $display("FAIL st_c%0d d_ack/if_ack got=%b exp=%b", c, {d_ack, if_ack}, (c == 2) ? 2'b10 : 2'b00); end
        end
        // The fetch follows directly. A store must leave the d_rdata hold at zero.
        next_cycle();
        d_req     = 1'b0;
        mem_rdata = 32'h22;
        @(negedge clk);
        total++; if ({mem_en, mem_we, if_ack, d_ack} !== 4'b1000)
            begin bad++; $display("FAIL st_c3 en/we/if_ack/d_ack got=%b exp=1000", {mem_en, mem_we, if_ack, d_ack}); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL st_c3_addr got=%h exp=100", mem_addr); end
        total++; if (mem_wdata !== 32'h7)  begin bad++; $display("FAIL st_c3_wdata got=%h exp=7", mem_wdata); end
        total++; if (d_rdata !== 32'h0)    begin bad++; $display("FAIL st_d_rdata got=%h exp=0", d_rdata); end
        next_cycle();
        @(negedge clk);
        total++; if ({mem_en, mem_we, if_ack} !== 3'b101)
            begin bad++; $display("FAIL st_c4 en/we/if_ack got=%b exp=101", {mem_en, mem_we, if_ack}); end
        total++; if (if_rdata !== 32'h22) begin bad++; $display("FAIL st_c4_if_rdata got=%h exp=22", if_rdata); end
    endtask

    task automatic test_back_to_back();
        logic        exp_d;
        logic        exp_ack;
        logic [31:0] exp_addr;
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h200;
        if_req  = 1'b1;
        if_addr = 32'h300;
        @(negedge clk);
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL b2b_c0_en got=%b exp=0", mem_en); end
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            mem_rdata = 32'hA000 + 32'(c);
            exp_d     = (((c - 1) / 2) % 2) == 0;
            exp_ack   = (c % 2) == 0;
            exp_addr  = exp_d ? 32'h200 : 32'h300;
            @(negedge clk);
            total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL b2b_c%0d_en got=%b exp=1", c, mem_en); end
            total++; if (mem_addr !== exp_addr)
                begin bad++; $display("FAIL b2b_c%0d_addr got=%h exp=%h", c, mem_addr, exp_addr); end
            total++; if ({d_ack, if_ack} !== {exp_d & exp_ack, ~exp_d & exp_ack})
                begin bad++; $display("FAIL b2b_c%0d d_ack/if_ack got=%b exp=%b", c, {d_ack, if_ack}, {exp_d & exp_ack, ~exp_d & exp_ack}); end
        end
        total++; if (d_rdata !== 32'hA006)  begin bad++; $display("FAIL b2b_d_hold got=%h exp=a006", d_rdata); end
        total++; if (if_rdata !== 32'hA008) begin bad++; $display("FAIL b2b_if_hold got=%h exp=a008", if_rdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h40;
        mem_rdata = 32'h99;
        next_cycle();
        @(negedge clk);
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rmid_c1_en got=%b exp=1", mem_en); end
        rst = 1'b0;
        next_cycle();
        rst   = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        total++; if ({mem_en, mem_we, d_ack} !== 3'b000)
            begin bad++; $display("FAIL rmid_c2 en/we/d_ack got=%b exp=000", {mem_en, mem_we, d_ack}); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h exp=0", mem_addr); end
        total++; if (d_rdata !== 32'h0)  begin bad++; $display("FAIL rmid_d_rdata got=%h exp=0", d_rdata); end
        next_cycle();
        @(negedge clk);
        total++; if ({mem_en, d_ack} !== 2'b00)
            begin bad++; $display("FAIL rmid_c3 en/d_ack got=%b exp=00", {mem_en, d_ack}); end
    endtask

    task automatic test_wait1_stream();
        logic [31:0] exp_addr;
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h1000;
        @(negedge clk);
        total++; if ({if_ack1, mem_en1} !== 2'b00)
            begin bad++; $display("FAIL w1_c0 ack/en got=%b exp=00", {if_ack1, mem_en1}); end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if_addr   = 32'h1000 + 32'(4 * c);
            mem_rdata = 32'hB000 + 32'(c);
            exp_addr  = 32'h1000 + 32'(4 * (c - 1));
            @(negedge clk);
            total++; if ({if_ack1, mem_en1, mem_we1, d_ack1, stall1} !== 5'b11000)
                begin bad++; $display("FAIL w1_c%0d ack/en/we/dack/stall got=%b exp=11000", c, {if_ack1, mem_en1, mem_we1, d_ack1, stall1}); end
            total++; if (mem_addr1 !== exp_addr)
                begin bad++; $display("FAIL w1_c%0d_addr got=%h exp=%h", c, mem_addr1, exp_addr); end
            total++; if (if_rdata1 !== 32'hB000 + 32'(c))
                begin bad++; $display("FAIL w1_c%0d_rdata got=%h exp=%h", c, if_rdata1, 32'hB000 + 32'(c)); end
        end
    endtask

    task automatic test_load_hold();
        do_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        next_cycle();
        mem_rdata = 32'h33;
        @(negedge clk);
        total++; if ({mem_en, d_ack} !== 2'b10)
            begin bad++; $display("FAIL ld_c1 en/ack got=%b exp=10", {mem_en, d_ack}); end
        // Dropping the request mid-transaction must not cancel the load.
        next_cycle();
        d_req     = 1'b0;
        mem_rdata = 32'h55;
        @(negedge clk);
        total++; if ({d_ack, mem_we, stall} !== 3'b100)
            begin bad++; $display("FAIL ld_c2 ack/we/stall got=%b exp=100", {d_ack, mem_we, stall}); end
        total++; if (d_rdata !== 32'h55) begin bad++; $display("FAIL ld_c2_rdata got=%h exp=55", d_rdata); end
        next_cycle();
        mem_rdata = 32'h77;
        @(negedge clk);
        total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL ld_c3_en got=%b exp=0", mem_en); end
        total++; if (d_rdata !== 32'h55) begin bad++; $display("FAIL ld_c3_hold got=%h exp=55", d_rdata); end
        total++; if (mem_addr !== 32'h80) begin bad++; $display("FAIL ld_c3_addr got=%h exp=80", mem_addr); end
        next_cycle();
        mem_rdata = 32'h12;
        @(negedge clk);
        total++; if (d_rdata !== 32'h55) begin bad++; $display("FAIL ld_c4_hold got=%h exp=55", d_rdata); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL ld_c4_if_rdata got=%h exp=0", if_rdata); end
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        test_reset();
        test_if_fetch();
        test_store_fetch();
        test_back_to_back();
        test_reset_mid();
        test_wait1_stream();
        test_load_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
